// File: rtl/inst_loader.sv
// Boot-time program loader: assembles a length-prefixed, XOR-checksummed byte stream
// into 32-bit words and writes them to instruction memory, holding the CPU in reset until verified.
module inst_loader #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [7:0]  byte_in_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic        imem_we_o,
    output logic [31:0] imem_addr_o,
    output logic [31:0] imem_wd_o,
    output logic        cpu_rst_o,
    output logic        done_o,
    output logic        err_o
);

    // state    | meaning
    // S_IDLE   | after reset, waiting for START, CPU held in reset
    // S_LEN_LO | expecting low byte of the word count
    // S_LEN_HI | expecting high byte of the word count, then range check
    // S_DATA   | receiving payload bytes, one memory write per 4 bytes
    // S_CHECK  | expecting the XOR checksum byte
    // S_RUN    | image verified, CPU released
    // S_FAIL   | length or checksum error, CPU held in reset
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_RUN, S_FAIL
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  len_lo_q, len_lo_d;
    logic [15:0] words_left_q, words_left_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [23:0] word_q, word_d;
    logic [7:0]  csum_q, csum_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] next_addr_q, next_addr_d;

    logic        xfer;
    logic [15:0] len_full;

    assign byte_ready_o = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                          (state_q == S_DATA)   || (state_q == S_CHECK);
    assign xfer         = byte_valid_i & byte_ready_o;
    assign len_full     = {byte_in_i, len_lo_q};

    always_comb begin
        state_d      = state_q;
        len_lo_d     = len_lo_q;
        words_left_d = words_left_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        csum_d       = csum_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        wd_d         = wd_q;
        next_addr_d  = next_addr_q;

        case (state_q)
            S_IDLE, S_RUN, S_FAIL: begin
                if (start_i) begin
                    state_d      = S_LEN_LO;
                    words_left_d = '0;
                    byte_idx_d   = '0;
                    word_d       = '0;
                    csum_d       = '0;
                    addr_d       = '0;
                    next_addr_d  = '0;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_lo_d = byte_in_i;
                    state_d  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    words_left_d = len_full;
                    if (len_full == 16'd0 || len_full > 16'(DEPTH_WORDS))
                        state_d = S_FAIL;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    csum_d     = csum_q ^ byte_in_i;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        we_d         = 1'b1;
                        wd_d         = {byte_in_i, word_q};
                        addr_d       = next_addr_q;
                        next_addr_d  = next_addr_q + 32'd4;
                        words_left_d = words_left_q - 16'd1;
                        if (words_left_q == 16'd1)
                            state_d = S_CHECK;
                    end else begin
                        word_d[8*byte_idx_q +: 8] = byte_in_i;
                    end
                end
            end
            S_CHECK: begin
                if (xfer)
                    state_d = (byte_in_i == csum_q) ? S_RUN : S_FAIL;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            len_lo_q     <= '0;
            words_left_q <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            csum_q       <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wd_q         <= '0;
            next_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            words_left_q <= words_left_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            csum_q       <= csum_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wd_q         <= wd_d;
            next_addr_q  <= next_addr_d;
        end
    end

    assign imem_we_o   = we_q;
    assign imem_addr_o = addr_q;
    assign imem_wd_o   = wd_q;
    assign cpu_rst_o   = (state_q != S_RUN);
    assign done_o      = (state_q == S_RUN);
    assign err_o       = (state_q == S_FAIL);

endmodule
